// File: rtl/spi_slave_if_if.sv
// SPI pins plus the byte-level handshake between the SPI slave and its transfer controller.
interface spi_slave_if_if;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_byte;
    logic        cycle_done;
    logic        busy;
    logic [16:0] frame_bytes;

    modport slave (
        input  sclk, cs_n, mosi, tx_byte,
        output miso, rx_byte, cycle_done, busy, frame_bytes
    );

    modport master (
        output sclk, cs_n, mosi, tx_byte,
        input  miso, rx_byte, cycle_done, busy, frame_bytes
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: oversamples sclk/cs_n/mosi in the clk domain, shifts bytes MSB first,
// and emits a DONE_WIDTH-clk cycle_done strobe after every completed byte.
module spi_slave_if #(
    parameter int DONE_WIDTH = 2
) (
    input logic            clk,
    input logic            rst,
    spi_slave_if_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_next;
    logic        sclk_s1, sclk_s2, sclk_s3;
    logic        cs_s1, cs_s2, cs_s3;
    logic        mosi_s1, mosi_s2;
    logic [1:0]  sync_valid;
    logic        armed;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [7:0]  rx_shift, rx_shift_next;
    logic [7:0]  rx_byte, rx_byte_next;
    logic [16:0] frame_bytes, frame_next;
    logic [7:0]  tx_shift;
    logic        start_pulse;
    logic        frame_start;
    logic        cycle_done;
    logic [2:0]  done_left;

    logic sclk_rise, sclk_fall, cs_fall;

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign cs_fall   = ~cs_s2 & cs_s3;

    // Synchronizers at idle levels; armed only once cs_n has really been sampled high,
    // so a cs_n held low across reset is not mistaken for a fresh falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s1    <= 1'b0;
            sclk_s2    <= 1'b0;
            sclk_s3    <= 1'b0;
            cs_s1      <= 1'b1;
            cs_s2      <= 1'b1;
            cs_s3      <= 1'b1;
            mosi_s1    <= 1'b0;
            mosi_s2    <= 1'b0;
            sync_valid <= '0;
            armed      <= 1'b0;
        end else begin
            sclk_s1    <= bus.sclk;
            sclk_s2    <= sclk_s1;
            sclk_s3    <= sclk_s2;
            cs_s1      <= bus.cs_n;
            cs_s2      <= cs_s1;
            cs_s3      <= cs_s2;
            mosi_s1    <= bus.mosi;
            mosi_s2    <= mosi_s1;
            sync_valid <= {sync_valid[0], 1'b1};
            armed      <= armed | (sync_valid[1] & cs_s2);
        end
    end

    // State and receive-side register bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_byte     <= '0;
            frame_bytes <= '0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            rx_shift    <= rx_shift_next;
            rx_byte     <= rx_byte_next;
            frame_bytes <= frame_next;
        end
    end

    // Next-state and receive datapath; DONE always issues its strobe even if cs_n has risen.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        rx_shift_next = rx_shift;
        rx_byte_next  = rx_byte;
        frame_next    = frame_bytes;
        start_pulse   = 1'b0;
        frame_start   = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && cs_fall) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    frame_next   = '0;
                    frame_start  = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_s2) begin
                    state_next = IDLE;
                end else if (sclk_rise) begin
                    rx_shift_next = {rx_shift[6:0], mosi_s2};
                    bit_cnt_next  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_byte_next = {rx_shift[6:0], mosi_s2};
                        state_next   = DONE;
                    end
                end
            end
            DONE: begin
                start_pulse  = 1'b1;
                bit_cnt_next = '0;
                if (frame_bytes != '1) begin
                    frame_next = frame_bytes + 17'd1;
                end
                state_next = cs_s2 ? IDLE : SHIFT;
            end
            default: state_next = IDLE;
        endcase
    end

    // Transmit shifter: load at frame start, reload at each byte boundary, else shift on sclk fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift <= '0;
        end else if (frame_start) begin
            tx_shift <= bus.tx_byte;
        end else if (state != IDLE && !cs_s2 && sclk_fall) begin
            if (bit_cnt == 3'd0) begin
                tx_shift <= bus.tx_byte;
            end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    // Strobe stretcher runs independently of the FSM so a started pulse always completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_done <= 1'b0;
            done_left  <= '0;
        end else if (start_pulse) begin
            cycle_done <= 1'b1;
            done_left  <= 3'(DONE_WIDTH - 1);
        end else if (done_left != 3'd0) begin
            done_left <= done_left - 3'd1;
        end else begin
            cycle_done <= 1'b0;
        end
    end

    assign bus.miso        = tx_shift[7];
    assign bus.rx_byte     = rx_byte;
    assign bus.cycle_done  = cycle_done;
    assign bus.busy        = (state != IDLE);
    assign bus.frame_bytes = frame_bytes;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed + randomized bench for spi_slave_if acting as SPI host and transfer controller.
module tb_spi_slave_if;

    localparam int DW = 3;

    logic clk;
    logic rst;
    spi_slave_if_if bus();

    spi_slave_if #(.DONE_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    int total = 0;
    int bad   = 0;

    logic [7:0] host [8];
    logic [7:0] txb  [8];
    logic [7:0] tx_q [$];
    logic [7:0] rx_seen [$];
    logic [7:0] miso_seen [$];
    int         widths [$];
    int         lats [$];
    int         pulses;
    int         tick_no = 0;
    int         last_rise = 0;
    int         hi_cnt = 0;
    logic       cd_prev = 1'b0;
    logic       busy_mid;
    logic [7:0] prev_rx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clk of time; also plays the transfer controller watching cycle_done.
    task tick();
        @(negedge clk);
        tick_no++;
        if (bus.cycle_done === 1'b1 && cd_prev === 1'b0) begin
            rx_seen.push_back(bus.rx_byte);
            lats.push_back(tick_no - last_rise);
            pulses++;
            if (tx_q.size() > 0) bus.tx_byte = tx_q.pop_front();
        end
        if (cd_prev === 1'b1 && bus.cycle_done !== 1'b1) widths.push_back(hi_cnt);
        hi_cnt  = (bus.cycle_done === 1'b1) ? hi_cnt + 1 : 0;
        cd_prev = bus.cycle_done;
    endtask

    task send_bits(input logic [7:0] b, input int nbits, input int half);
        logic [7:0] mb;
        mb = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.mosi = b[i];
            repeat (half) tick();
            mb = {mb[6:0], bus.miso};
            bus.sclk = 1'b1;
            last_rise = tick_no;
            repeat (half) tick();
            bus.sclk = 1'b0;
        end
        if (nbits == 8) miso_seen.push_back(mb);
    endtask

    task do_frame(input int n, input int half);
        rx_seen.delete(); miso_seen.delete(); widths.delete(); lats.delete(); tx_q.delete();
        pulses = 0;
        bus.tx_byte = txb[0];
        for (int k = 1; k < n; k++) tx_q.push_back(txb[k]);
        bus.cs_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            send_bits(host[k], 8, half);
            if (k == 0) busy_mid = bus.busy;
        end
        repeat (half) tick();
        bus.cs_n = 1'b1;
        repeat (8) tick();
    endtask

    // Expected behaviour: every host byte shows up at a strobe, every tx byte on miso.
    task check_frame(input string name, input int n);
        chk({name, " pulses"}, pulses, n);
        chk({name, " busy_mid"}, {31'd0, busy_mid}, 1);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s rx[%0d]", name, k),
                (k < rx_seen.size()) ? {24'd0, rx_seen[k]} : 32'hDEAD_BEEF, {24'd0, host[k]});
            chk($sformatf("%s miso[%0d]", name, k),
                (k < miso_seen.size()) ? {24'd0, miso_seen[k]} : 32'hDEAD_BEEF, {24'd0, txb[k]});
            chk($sformatf("%s width[%0d]", name, k),
                (k < widths.size()) ? widths[k] : -1, DW);
            chk($sformatf("%s lat_ok[%0d]", name, k),
                (k < lats.size() && (lats[k] == 4 || lats[k] == 5)) ? 1 : 0, 1);
        end
        chk({name, " frame_bytes"}, {15'd0, bus.frame_bytes}, n);
        chk({name, " busy_end"}, {31'd0, bus.busy}, 0);
    endtask

    task check_reset_outputs(input string name);
        chk({name, " miso"}, {31'd0, bus.miso}, 0);
        chk({name, " rx_byte"}, {24'd0, bus.rx_byte}, 0);
        chk({name, " cycle_done"}, {31'd0, bus.cycle_done}, 0);
        chk({name, " busy"}, {31'd0, bus.busy}, 0);
        chk({name, " frame_bytes"}, {15'd0, bus.frame_bytes}, 0);
    endtask

    initial begin
        int n;
        int half;
        rst = 1'b0;
        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0; bus.tx_byte = 8'h00;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (5) tick();

        // sclk activity with cs_n high must be invisible
        pulses = 0;
        bus.tx_byte = 8'hFF;
        repeat (16) begin
            bus.sclk = ~bus.sclk;
            repeat (4) tick();
        end
        bus.sclk = 1'b0;
        repeat (4) tick();
        chk("cs_high pulses", pulses, 0);
        chk("cs_high frame_bytes", {15'd0, bus.frame_bytes}, 0);
        chk("cs_high miso", {31'd0, bus.miso}, 0);

        // single byte A5 / 3C
        host[0] = 8'hA5; txb[0] = 8'h3C;
        do_frame(1, DW + 4);
        check_frame("single", 1);

        // five-byte frame at minimum sclk low time, controller updating tx_byte on each strobe
        host[0] = 8'h05; host[1] = 8'h00; host[2] = 8'hF0; host[3] = 8'h01; host[4] = 8'h40;
        txb[0]  = 8'h5A; txb[1]  = 8'h11; txb[2]  = 8'h22; txb[3]  = 8'h33; txb[4]  = 8'h44;
        do_frame(5, DW + 4);
        check_frame("five", 5);

        // partial byte aborted by cs_n
        prev_rx = 8'h40;
        pulses = 0;
        bus.tx_byte = 8'hC3;
        bus.cs_n = 1'b0;
        send_bits(8'hFF, 5, DW + 4);
        bus.cs_n = 1'b1;
        repeat (10) tick();
        chk("partial pulses", pulses, 0);
        chk("partial rx_byte", {24'd0, bus.rx_byte}, {24'd0, prev_rx});
        chk("partial busy", {31'd0, bus.busy}, 0);
        host[0] = 8'h96; txb[0] = 8'h69;
        do_frame(1, DW + 5);
        check_frame("after_partial", 1);

        // reset in the middle of a byte with cs_n still low
        pulses = 0;
        bus.tx_byte = 8'hE7;
        bus.cs_n = 1'b0;
        send_bits(8'hAA, 3, DW + 4);
        rst = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst = 1'b1;
        send_bits(8'h5B, 8, DW + 4);
        repeat (10) tick();
        chk("midreset pulses", pulses, 0);
        chk("midreset rx_byte", {24'd0, bus.rx_byte}, 0);
        chk("midreset frame_bytes", {15'd0, bus.frame_bytes}, 0);
        chk("midreset miso", {31'd0, bus.miso}, 0);
        bus.cs_n = 1'b1;
        repeat (6) tick();
        host[0] = 8'h3E; txb[0] = 8'hD2;
        do_frame(1, DW + 4);
        check_frame("after_reset", 1);

        // randomized frames
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(1, 6);
            half = $urandom_range(DW + 4, DW + 8);
            for (int k = 0; k < 8; k++) begin
                host[k] = 8'($urandom);
                txb[k]  = 8'($urandom);
            end
            do_frame(n, half);
            check_frame($sformatf("rand%0d", f), n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
